// File: rtl/apu_dmc.sv
// apu_dmc: APU delta-modulation channel.
//
// Fetches 1-bit delta sample bytes over a request/acknowledge DMA port into a
// small prefetch FIFO, and plays them out as a stepped output level.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   apu_cycle       one-clk pulse per APU cycle (output timer tick)
//   en              channel enable ($4015 bit 4)
//   enable_write    pulse on any $4015 write
//   reg_ctrl        $4010: [7] irq_en, [6] loop, [3:0] rate
//   reg_direct      $4011: [6:0] direct level load value
//   reg_addr        $4012: sample start address
//   reg_length      $4013: sample length
//   ctrl_update     pulse, reg_ctrl was written
//   direct_update   pulse, reg_direct was written
//   dma_req         byte fetch request, held until dma_ack
//   dma_addr        fetch address, stable while dma_req is high
//   dma_ack         one-clk acknowledge, dma_data valid in the same clk
//   dma_data        fetched byte
//   irq             DMC interrupt flag
//   active          bytes remain to be fetched
//   sample          output level for the mixer
module apu_dmc #(
    parameter int unsigned OUT_WIDTH  = 7,
    parameter int unsigned FIFO_DEPTH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 apu_cycle,
    input  logic                 en,
    input  logic                 enable_write,
    input  logic [7:0]           reg_ctrl,
    input  logic [7:0]           reg_direct,
    input  logic [7:0]           reg_addr,
    input  logic [7:0]           reg_length,
    input  logic                 ctrl_update,
    input  logic                 direct_update,
    output logic                 dma_req,
    output logic [15:0]          dma_addr,
    input  logic                 dma_ack,
    input  logic [7:0]           dma_data,
    output logic                 irq,
    output logic                 active,
    output logic [OUT_WIDTH-1:0] sample
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    // One delta step is 2 units of the 7-bit NES level, scaled to OUT_WIDTH.
    localparam logic [OUT_WIDTH-1:0] STEP = OUT_WIDTH'(2 << (OUT_WIDTH - 7));
    localparam logic [OUT_WIDTH-1:0] MAX_LEVEL = '1;

    typedef enum logic [0:0] {StIdle, StReq} state_t;

    state_t           state;
    logic [15:0]      cur_addr;
    logic [11:0]      bytes_remaining;
    logic [7:0]       timer;
    logic [7:0]       shift;
    logic [3:0]       bits_remaining;
    logic             silence;
    logic [OUT_WIDTH-1:0] level;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;

    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             out_clk;
    logic [15:0]      start_addr;
    logic [11:0]      start_len;
    logic [15:0]      next_addr;
    logic [OUT_WIDTH-1:0] direct_level;
    logic             unused_bits;

    function automatic logic [7:0] period_m1(input logic [3:0] rate);
        unique case (rate)
            4'd0:  return 8'd213;
            4'd1:  return 8'd189;
            4'd2:  return 8'd169;
            4'd3:  return 8'd159;
            4'd4:  return 8'd142;
            4'd5:  return 8'd126;
            4'd6:  return 8'd112;
            4'd7:  return 8'd106;
            4'd8:  return 8'd94;
            4'd9:  return 8'd79;
            4'd10: return 8'd70;
            4'd11: return 8'd63;
            4'd12: return 8'd52;
            4'd13: return 8'd41;
            4'd14: return 8'd35;
            4'd15: return 8'd26;
        endcase
    endfunction

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign start_addr   = 16'hC000 + {2'b00, reg_addr, 6'b000000};
    assign start_len    = {reg_length, 4'b0000} + 12'd1;
    // Sample fetches never leave the upper half of the address space.
    assign next_addr    = (cur_addr == 16'hFFFF) ? 16'h8000 : cur_addr + 16'd1;
    assign direct_level = OUT_WIDTH'(reg_direct[6:0]) << (OUT_WIDTH - 7);
    assign unused_bits  = ^{reg_ctrl[5:4], reg_direct[7]};

    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    // Only an ack that answers our own request carries a byte.
    assign push       = (state == StReq) && dma_ack;
    assign out_clk    = apu_cycle && (timer == 8'd0);
    assign pop        = out_clk && (bits_remaining == 4'd1) && !fifo_empty;

    assign active = (bytes_remaining != 12'd0);
    assign sample = level;

    // Reader: fetch sequencing, address/length bookkeeping and IRQ.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= StIdle;
            dma_req         <= 1'b0;
            dma_addr        <= 16'hC000;
            cur_addr        <= 16'hC000;
            bytes_remaining <= 12'd0;
            irq             <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (bytes_remaining != 12'd0 && !fifo_full) begin
                        state    <= StReq;
                        dma_req  <= 1'b1;
                        dma_addr <= cur_addr;
                    end
                end
                StReq: begin
                    if (dma_ack) begin
                        state   <= StIdle;
                        dma_req <= 1'b0;
                        // A count of zero here means the transfer was cancelled.
                        if (bytes_remaining != 12'd0) begin
                            if (bytes_remaining == 12'd1 && reg_ctrl[6]) begin
                                cur_addr        <= start_addr;
                                bytes_remaining <= start_len;
                            end else begin
                                cur_addr        <= next_addr;
                                bytes_remaining <= bytes_remaining - 12'd1;
                                if (bytes_remaining == 12'd1 && reg_ctrl[7]) begin
                                    irq <= 1'b1;
                                end
                            end
                        end
                    end
                end
            endcase

            // Register writes override the ack bookkeeping of the same clk.
            if (enable_write) begin
                irq <= 1'b0;
                if (!en) begin
                    bytes_remaining <= 12'd0;
                end else if (bytes_remaining == 12'd0) begin
                    cur_addr        <= start_addr;
                    bytes_remaining <= start_len;
                end
            end
            if (ctrl_update && !reg_ctrl[7]) begin
                irq <= 1'b0;
            end
        end
    end

    // Output timer and output unit.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer          <= period_m1(4'd0);
            shift          <= 8'd0;
            bits_remaining <= 4'd8;
            silence        <= 1'b1;
            level          <= '0;
        end else begin
            if (apu_cycle) begin
                timer <= (timer == 8'd0) ? period_m1(reg_ctrl[3:0]) : timer - 8'd1;
            end
            if (out_clk) begin
                if (!silence) begin
                    if (shift[0]) begin
                        if (level <= MAX_LEVEL - STEP) level <= level + STEP;
                    end else begin
                        if (level >= STEP) level <= level - STEP;
                    end
                end
                if (bits_remaining == 4'd1) begin
                    bits_remaining <= 4'd8;
                    if (!fifo_empty) begin
                        shift   <= fifo_mem[rd_ptr];
                        silence <= 1'b0;
                    end else begin
                        shift   <= {1'b0, shift[7:1]};
                        silence <= 1'b1;
                    end
                end else begin
                    bits_remaining <= bits_remaining - 4'd1;
                    shift          <= {1'b0, shift[7:1]};
                end
            end
            if (direct_update) begin
                level <= direct_level;
            end
        end
    end

    // Prefetch FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= dma_data;
    end

endmodule
